// File: rtl/fp_result_writeback.sv
// ---------------------------------------------------------------------------
// fp_result_writeback
//
// Consumer end of the FP execute stage. Completed results (value, exception
// flags, destination) arrive through a valid/ready handshake and wait in a
// small FIFO. The head entry is presented to the FP or integer register-file
// write port and retires when that port grants the write. Exception flags
// are accrued into fcsr.fflags as each result retires. fcsr (fflags + frm)
// is readable and writable through a small CSR port.
//
// Ports
//   clk, reset                : core clock; asynchronous active-high reset
//   in_valid/in_ready         : result handshake from execute
//   in_rd/in_result/in_fflags : destination index, value, NV,DZ,OF,UF,NX
//   in_to_int                 : 1 = integer RF destination, 0 = FP RF
//   fp_we/fp_waddr/fp_wdata   : FP RF write request, held until fp_wgrant
//   int_we/int_waddr/int_wdata: integer RF write request, held until int_wgrant
//   csr_we/csr_addr/csr_wdata : fcsr write (01 fflags, 10 frm, 11 fcsr)
//   csr_rdata                 : combinational read of the addressed CSR
//   frm, fflags_acc           : architectural rounding mode and accrued flags
//   busy                      : FIFO holds at least one result
// ---------------------------------------------------------------------------
module fp_result_writeback #(
    parameter int DEPTH = 2,   // 2 or 4; pointers wrap naturally at a power of two
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_result,
    input  logic [4:0]      in_fflags,
    input  logic            in_to_int,

    output logic            fp_we,
    output logic [4:0]      fp_waddr,
    output logic [XLEN-1:0] fp_wdata,
    input  logic            fp_wgrant,

    output logic            int_we,
    output logic [4:0]      int_waddr,
    output logic [XLEN-1:0] int_wdata,
    input  logic            int_wgrant,

    input  logic            csr_we,
    input  logic [1:0]      csr_addr,
    input  logic [7:0]      csr_wdata,
    output logic [7:0]      csr_rdata,

    output logic [2:0]      frm,
    output logic [4:0]      fflags_acc,
    output logic            busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [4:0]      fflags;
        logic            to_int;
    } entry_t;

    localparam logic [1:0] CSR_FFLAGS = 2'b01;
    localparam logic [1:0] CSR_FRM    = 2'b10;
    localparam logic [1:0] CSR_FCSR   = 2'b11;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    entry_t             head;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic [4:0]         fflags_next;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = !full;
    assign busy     = !empty;
    assign head     = mem[rd_ptr];

    // No pass-through: a full FIFO refuses a push even when the head retires
    // in the same cycle, which keeps in_ready free of any grant path.
    assign push = in_valid && in_ready;

    // An integer write to x0 has no architectural effect, so it retires
    // without waiting for the integer port.
    assign pop = !empty &&
                 ((!head.to_int && fp_wgrant) ||
                  ( head.to_int && (int_wgrant || head.rd == 5'd0)));

    // Head drive. Everything is gated by !empty so stale storage never
    // reaches the register-file ports.
    always_comb begin
        // NOTE: every output gets a default first so no path through this block leaves a value unassigned, which would infer a latch.
        fp_we     = 1'b0;
        fp_waddr  = '0;
        fp_wdata  = '0;
        int_we    = 1'b0;
        int_waddr = '0;
        int_wdata = '0;
        if (!empty) begin
            if (head.to_int) begin
                int_we    = (head.rd != 5'd0);
                int_waddr = head.rd;
                int_wdata = head.result;
            end else begin
                fp_we    = 1'b1;
                fp_waddr = head.rd;
                fp_wdata = head.result;
            end
        end
    end

    // A CSR write lands first; flags of a result retiring in the same cycle
    // are then ORed on top so they are never lost.
    always_comb begin
        fflags_next = fflags_acc;
        if (csr_we && (csr_addr == CSR_FFLAGS || csr_addr == CSR_FCSR))
            fflags_next = csr_wdata[4:0];
        if (pop)
            fflags_next = fflags_next | head.fflags;
    end

    always_comb begin
        unique case (csr_addr)
            CSR_FFLAGS: csr_rdata = {3'b000, fflags_acc};
            CSR_FRM:    csr_rdata = {5'b00000, frm};
            CSR_FCSR:   csr_rdata = {frm, fflags_acc};
            default:    csr_rdata = 8'h00;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; count gates every use of it, and leaving it reset-free lets it map onto plain registers or LUT RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: in_rd, result: in_result, fflags: in_fflags, to_int: in_to_int};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // fcsr. Illegal rounding modes are stored as written; decode flags them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fflags_acc <= '0;
            frm        <= '0;
        end else begin
            fflags_acc <= fflags_next;
            if (csr_we && csr_addr == CSR_FRM)
                frm <= csr_wdata[2:0];
            else if (csr_we && csr_addr == CSR_FCSR)
                frm <= csr_wdata[7:5];
        end
    end

endmodule

// File: tb/tb_fp_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_fp_result_writeback
//
// Self-checking bench for fp_result_writeback. Inputs change 1 time unit
// after the rising edge; a monitor on the falling edge compares the DUT
// against a scoreboard queue of buffered results plus an fcsr model, then
// advances the model with the inputs that the next rising edge will see.
// Directed sequences add checks against hand-derived constants.
// ---------------------------------------------------------------------------
module tb_fp_result_writeback;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic [4:0]      fflags;
        logic            to_int;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_result;
    logic [4:0]      in_fflags;
    logic            in_to_int;
    logic            fp_we;
    logic [4:0]      fp_waddr;
    logic [XLEN-1:0] fp_wdata;
    logic            fp_wgrant;
    logic            int_we;
    logic [4:0]      int_waddr;
    logic [XLEN-1:0] int_wdata;
    logic            int_wgrant;
    logic            csr_we;
    logic [1:0]      csr_addr;
    logic [7:0]      csr_wdata;
    logic [7:0]      csr_rdata;
    logic [2:0]      frm;
    logic [4:0]      fflags_acc;
    logic            busy;

    fp_result_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_result(in_result), .in_fflags(in_fflags), .in_to_int(in_to_int),
        .fp_we(fp_we), .fp_waddr(fp_waddr), .fp_wdata(fp_wdata), .fp_wgrant(fp_wgrant),
        .int_we(int_we), .int_waddr(int_waddr), .int_wdata(int_wdata), .int_wgrant(int_wgrant),
        .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .frm(frm), .fflags_acc(fflags_acc), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_retired = 0;
    bit   mon_en = 1'b0;
    exp_t sb[$];
    logic [4:0] m_flags = '0;
    logic [2:0] m_frm = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: compare current state, then step the model.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            m_flags = '0;
            m_frm   = '0;
        end else if (mon_en) begin
            exp_t       h;
            logic       do_pop;
            logic [7:0] exp_rd;
            check("mon_busy", 32'(busy), 32'(sb.size() != 0));
            check("mon_in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
            check("mon_fflags", 32'(fflags_acc), 32'(m_flags));
            check("mon_frm", 32'(frm), 32'(m_frm));
            case (csr_addr)
                2'b01:   exp_rd = {3'b000, m_flags};
                2'b10:   exp_rd = {5'b00000, m_frm};
                2'b11:   exp_rd = {m_frm, m_flags};
                default: exp_rd = 8'h00;
            endcase
            check("mon_csr_rdata", 32'(csr_rdata), 32'(exp_rd));
            do_pop = 1'b0;
            if (sb.size() == 0) begin
                check("mon_idle_we", {30'd0, fp_we, int_we}, 32'd0);
                check("mon_idle_addr", {22'd0, fp_waddr, int_waddr}, 32'd0);
                check("mon_idle_fp_wdata", fp_wdata, 32'd0);
                check("mon_idle_int_wdata", int_wdata, 32'd0);
            end else begin
                h = sb[0];
                if (!h.to_int) begin
                    check("mon_fp_we", 32'(fp_we), 32'd1);
                    check("mon_fp_waddr", 32'(fp_waddr), 32'(h.rd));
                    check("mon_fp_wdata", fp_wdata, h.result);
                    check("mon_int_off", {int_we, 26'd0, int_waddr}, 32'd0);
                    check("mon_int_wdata_off", int_wdata, 32'd0);
                    do_pop = fp_wgrant;
                end else begin
                    check("mon_int_we", 32'(int_we), 32'(h.rd != 5'd0));
                    check("mon_int_waddr", 32'(int_waddr), 32'(h.rd));
                    check("mon_int_wdata", int_wdata, h.result);
                    check("mon_fp_off", {fp_we, 26'd0, fp_waddr}, 32'd0);
                    check("mon_fp_wdata_off", fp_wdata, 32'd0);
                    do_pop = int_wgrant || (h.rd == 5'd0);
                end
            end
            // Model step for the coming rising edge.
            if (csr_we && csr_addr[0]) m_flags = csr_wdata[4:0];
            if (do_pop) m_flags = m_flags | h.fflags;
            if (csr_we && csr_addr == 2'b10) m_frm = csr_wdata[2:0];
            if (csr_we && csr_addr == 2'b11) m_frm = csr_wdata[7:5];
            if (in_valid && sb.size() < DEPTH)
                sb.push_back('{rd: in_rd, result: in_result, fflags: in_fflags, to_int: in_to_int});
            if (do_pop) begin
                void'(sb.pop_front());
                n_retired++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] rd, input logic [31:0] res,
                         input logic [4:0] fl, input logic ti);
        in_valid  = 1'b1;
        in_rd     = rd;
        in_result = res;
        in_fflags = fl;
        in_to_int = ti;
    endtask

    task automatic csr_write(input logic [1:0] addr, input logic [7:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick();
        csr_we    = 1'b0;
        csr_addr  = 2'b00;
    endtask

    // Bounded wait for the FIFO to empty; an expired budget is a failure.
    task automatic drain(input string tag);
        for (int i = 0; i < 20 && busy; i++) tick();
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int r0;
        reset = 1'b1;
        in_valid = 1'b0; in_rd = '0; in_result = '0; in_fflags = '0; in_to_int = 1'b0;
        fp_wgrant = 1'b0; int_wgrant = 1'b0;
        csr_we = 1'b0; csr_addr = 2'b00; csr_wdata = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", {30'd0, fp_we, int_we}, 32'd0);
        check("rst_fcsr", {24'd0, frm, fflags_acc}, 32'd0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Single FP result: visible the cycle after the push, retires on grant.
        fp_wgrant = 1'b1;
        drive(5'd5, 32'h3F800000, 5'b00001, 1'b0);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("single_fp_we", 32'(fp_we), 32'd1);
        check("single_fp_waddr", 32'(fp_waddr), 32'd5);
        check("single_fp_wdata", fp_wdata, 32'h3F800000);
        tick();
        @(negedge clk);
        check("single_fflags", 32'(fflags_acc), 32'h01);
        check("single_busy", 32'(busy), 32'd0);
        tick();

        // Backpressure: fill with the grant low, a third push is refused.
        fp_wgrant = 1'b0;
        drive(5'd10, 32'hAAAA0001, 5'b00010, 1'b0);
        tick();
        drive(5'd11, 32'hAAAA0002, 5'b00000, 1'b0);
        tick();
        drive(5'd12, 32'hAAAA0003, 5'b00000, 1'b0);
        @(negedge clk);
        check("bp_full_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        fp_wgrant = 1'b1;
        @(negedge clk);
        check("bp_first_waddr", 32'(fp_waddr), 32'd10);
        tick();
        @(negedge clk);
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        check("bp_second_waddr", 32'(fp_waddr), 32'd11);
        tick();
        @(negedge clk);
        check("bp_drained", 32'(busy), 32'd0);
        tick();

        // Integer x0: retires without a write, flags still accrue.
        csr_write(2'b01, 8'h00);
        fp_wgrant = 1'b0; int_wgrant = 1'b0;
        drive(5'd0, 32'h12345678, 5'b10000, 1'b1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("x0_int_we", 32'(int_we), 32'd0);
        check("x0_busy", 32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("x0_retired", 32'(busy), 32'd0);
        check("x0_fflags", 32'(fflags_acc), 32'h10);
        tick();

        // CSR write colliding with a retiring result.
        csr_write(2'b01, 8'h03);
        drive(5'd7, 32'h40490FDB, 5'b00100, 1'b0);
        tick();
        in_valid = 1'b0;
        csr_we = 1'b1; csr_addr = 2'b01; csr_wdata = 8'h00;
        fp_wgrant = 1'b1;
        tick();
        csr_we = 1'b0;
        @(negedge clk);
        check("collide_fflags", 32'(fflags_acc), 32'h04);
        tick();
        csr_write(2'b11, 8'h85);
        csr_addr = 2'b11;
        @(negedge clk);
        check("fcsr_frm", 32'(frm), 32'd4);
        check("fcsr_fflags", 32'(fflags_acc), 32'h05);
        check("fcsr_rdata", 32'(csr_rdata), 32'h85);
        tick();
        csr_addr = 2'b10;
        @(negedge clk);
        check("frm_rdata", 32'(csr_rdata), 32'h04);
        tick();
        csr_addr = 2'b00;

        // Asynchronous reset with two entries queued.
        csr_write(2'b10, 8'h01);
        fp_wgrant = 1'b0;
        drive(5'd20, 32'hDEAD0001, 5'b00001, 1'b0);
        tick();
        drive(5'd21, 32'hDEAD0002, 5'b00010, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        fp_wgrant = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_we", {30'd0, fp_we, int_we}, 32'd0);
        check("arst_addr", {22'd0, fp_waddr, int_waddr}, 32'd0);
        check("arst_fp_wdata", fp_wdata, 32'd0);
        check("arst_frm", 32'(frm), 32'd0);
        check("arst_fflags", 32'(fflags_acc), 32'd0);
        tick();
        reset = 1'b0;
        fp_wgrant = 1'b0;
        tick();

        // Wrap-around: ten back-to-back push/pop pairs with both grants high.
        fp_wgrant = 1'b1; int_wgrant = 1'b1;
        r0 = n_retired;
        for (int i = 0; i < 10; i++) begin
            drive(5'(i + 1), 32'hC0DE0000 + 32'(i), 5'(1 << (i % 5)), 1'(i % 2));
            tick();
            if (i > 0) check("wrap_count_one", 32'(busy && in_ready), 32'd1);
        end
        in_valid = 1'b0;
        drain("wrap_drain");
        tick();
        check("wrap_retired", 32'(n_retired - r0), 32'd10);
        check("wrap_sb_empty", 32'(sb.size()), 32'd0);
        check("wrap_fflags", 32'(fflags_acc), 32'h1F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_result_writeback.md
Name: fp_result_writeback

Overview:
- Consumer end of the FP execute stage's result/flag interface.
- Accepts completed FP results (result, fflags, destination) through a valid/ready handshake and buffers them in a small FIFO.
- Retires each result to the FP or integer register-file write port when that port grants access.
- Accrues exception flags into the architectural fcsr (fflags + frm) at retirement and provides CSR read/write access to fcsr.

Parameters:
DEPTH, 2, FIFO entries; legal values 2 or 4.
XLEN, 32, result data width.

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  asynchronous, active-high; clears FIFO and fcsr.
in_valid  in  1  execute stage presents a completed result.
in_ready  out  1  FIFO can accept this cycle.
in_rd  in  5  destination register index.
in_result  in  XLEN  result value.
in_fflags  in  5  NV,DZ,OF,UF,NX (bit4..0) raised by this op.
in_to_int  in  1  1 = destination is the integer RF (fcvt.w, feq, fclass, fmv.x.w); 0 = FP RF.
fp_we  out  1  FP RF write request.
fp_waddr  out  5  FP RF write index.
fp_wdata  out  XLEN  FP RF write data.
fp_wgrant  in  1  FP write port granted this cycle.
int_we  out  1  integer RF write request.
int_waddr  out  5  integer RF write index.
int_wdata  out  XLEN  integer RF write data.
int_wgrant  in  1  integer write port granted this cycle.
csr_we  in  1  CSR write strobe.
csr_addr  in  2  01 = fflags, 10 = frm, 11 = fcsr; 00 = no-op.
csr_wdata  in  8  CSR write data (low bits used per address).
csr_rdata  out  8  current value of the addressed CSR, zero-extended; combinational.
frm  out  3  current dynamic rounding mode.
fflags_acc  out  5  current accrued flags.
busy  out  1  FIFO non-empty.

Behaviour:
- Reset values:
  - FIFO is empty; pointers and count are 0.
  - fflags_acc, frm and busy are 0.
  - fp_we, int_we are 0; waddr/wdata outputs are 0.
- Push:
  - Occurs when in_valid && in_ready.
  - in_ready = !full. There is no same-cycle pass-through, so a full FIFO with a simultaneous pop still deasserts in_ready.
- Latency:
  - An entry pushed at cycle N is at the head and visible on the write port at N+1 at the earliest, if the FIFO was empty.
- Head drive:
  - When non-empty and head.to_int = 0: fp_we = 1, fp_waddr = head.rd, fp_wdata = head.result.
  - When non-empty and head.to_int = 1: int_we = 1 unless head.rd == 0, with int_waddr/int_wdata driven the same way.
  - The idle port's addr/data are driven to 0.
  - When empty, all write outputs are 0.
- Pop (retire) occurs when:
  - non-empty && ((!to_int && fp_wgrant) || (to_int && (int_wgrant || rd == 0))).
  - An integer destination of x0 retires without a write, and its flags are still accrued.
- Grants arriving while the FIFO is empty, or on the non-selected port, are ignored.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo DEPTH.
- Flag accrual: on pop, fflags_acc <= fflags_acc | head.fflags. Flags are never accrued at push.
- CSR write:
  - Address 01: fflags_acc <= wdata[4:0].
  - Address 10: frm <= wdata[2:0].
  - Address 11: fflags_acc <= wdata[4:0] and frm <= wdata[7:5].
- CSR write in the same cycle as a pop targeting fflags: fflags_acc <= csr_wdata[4:0] | head.fflags, i.e. the write lands first and the retiring flags OR on top.
- frm is not otherwise modified. Illegal frm values (101–111) are stored as written; flagging them is decode's job.
- csr_rdata reads state before the edge:
  - 01 gives {3'b0, fflags}.
  - 10 gives {5'b0, frm}.
  - 11 gives {frm, fflags}.
  - 00 gives 0.
- Reset mid-operation discards all buffered results with no writes; in-flight grants are ignored.
- busy = (count != 0).

Test Plan:
- Single FP result: push rd=5, result=0x3F800000, fflags=00001, to_int=0; fp_wgrant=1 → fp_we at cycle+1 with waddr 5 and wdata 0x3F800000; pop that cycle; fflags_acc=00001; busy returns to 0.
- Backpressure: fill DEPTH=2 with fp_wgrant=0 → in_ready=0 and a third push is refused; raise grant → entries retire in order, one per cycle, and in_ready reasserts the cycle after the first pop.
- Integer x0 destination: push to_int=1, rd=0, fflags=10000 with int_wgrant=0 → int_we stays 0, the entry retires next cycle, fflags_acc=10000.
- CSR/pop collision: fflags_acc=00011; csr_we with addr=01, wdata=0x00 in the same cycle as a pop carrying 00100 → fflags_acc=00100. Then csr write addr=11, wdata=0x85 → frm=100, fflags=00101, csr_rdata(11)=0x85.
- Async reset: assert reset mid-stream with 2 entries queued and frm=001 → FIFO empty, all write outputs 0, frm=000, fflags_acc=0 immediately, without waiting for a clock edge.
- Wrap-around: 10 back-to-back push/pop pairs with both grants held high → count stays 1; every result is written once in order with no duplication or loss.
